// File: rtl/sram_pkg.sv
// Shared widths and the response record for the SKY130 32x512 SRAM port-0 adapter.
package sram_pkg;

  localparam int SRAM_ADDR_WIDTH = 9;
  localparam int SRAM_DATA_WIDTH = 32;
  localparam int SRAM_NUM_WMASKS = SRAM_DATA_WIDTH / 8;

  typedef struct packed {
    logic                       we;
    logic [SRAM_DATA_WIDTH-1:0] rdata;
  } sram_rsp_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous FIFO of sram_rsp_t; the head is presented combinationally and forced to zero when empty.
module sram_rsp_fifo
  import sram_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  sram_rsp_t        push_data_i,
  input  logic             pop_i,
  output sram_rsp_t        head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  sram_rsp_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_en, pop_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers define validity and the head is gated by empty_o.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/sram_port0_adapter.sv
// Valid/ready front-end for port 0 of the SKY130 32x512 SRAM: issue register (S1),
// read-data capture (S2), credit counter and an ordered response FIFO.
module sram_port0_adapter
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int NUM_WMASKS = SRAM_NUM_WMASKS,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam int OUT_W = $clog2(RSP_DEPTH + 1);
  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

  logic                  csb_q, web_q;
  logic [NUM_WMASKS-1:0] wmask_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  s2_valid_q, s2_we_q;
  logic [OUT_W-1:0]      outstanding_q, outstanding_d;
  logic                  req_ready_q, req_ready_d;
  logic                  accept, pop;
  sram_rsp_t             push_data, head;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty, fifo_full;

  assign accept = req_valid && req_ready_q;
  assign pop    = rsp_valid && rsp_ready;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !pop)      outstanding_d = outstanding_q + OUT_W'(1);
    else if (!accept && pop) outstanding_d = outstanding_q - OUT_W'(1);
    req_ready_d = (outstanding_d < OUT_W'(RSP_DEPTH));
    push_data       = '0;
    push_data.we    = s2_we_q;
    push_data.rdata = s2_we_q ? '0 : sram_dout0;
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      csb_q         <= 1'b1;
      web_q         <= 1'b1;
      wmask_q       <= '0;
      addr_q        <= '0;
      din_q         <= '0;
      s2_valid_q    <= 1'b0;
      s2_we_q       <= 1'b0;
      outstanding_q <= '0;
      req_ready_q   <= 1'b0;
    end else begin
      csb_q <= !accept;
      if (accept) begin
        web_q   <= !req_we;
        wmask_q <= req_wmask;
        addr_q  <= req_addr;
        din_q   <= req_wdata;
      end
      // The macro drives dout one cycle after it latches, so S2 trails S1 by exactly one cycle.
      s2_valid_q    <= !csb_q;
      s2_we_q       <= !web_q;
      outstanding_q <= outstanding_d;
      req_ready_q   <= req_ready_d;
    end
  end

  sram_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (s2_valid_q),
    .push_data_i(push_data),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  assign req_ready   = req_ready_q;
  assign rsp_valid   = !fifo_empty;
  assign rsp_we      = head.we;
  assign rsp_rdata   = head.rdata;
  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = wmask_q;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;

  // Credits reserve a FIFO slot at accept time, so a push never meets a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(s2_valid_q && fifo_full));
  a_credit_sum: assert property (@(posedge clk) disable iff (rst)
    outstanding_q == OUT_W'(!csb_q) + OUT_W'(s2_valid_q) + OUT_W'(fifo_count));

endmodule

// File: tb/tb_sram_port0_adapter.sv
// Directed bench for sram_port0_adapter with a behavioural model of the SKY130 SRAM port 0.
module tb_sram_port0_adapter;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_valid, rsp_ready, rsp_we;
  logic [31:0] rsp_rdata;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;

  int checks = 0;
  int errors = 0;

  sram_port0_adapter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_we     (rsp_we),
    .rsp_rdata  (rsp_rdata),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_wmask0(sram_wmask0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: latch pins on the rising edge, commit writes / drive dout on the falling edge.
  logic [31:0] mem [512];
  bit          mem_loaded;
  logic        m_csb = 1'b1;
  logic        m_web = 1'b1;
  logic [3:0]  m_wmask;
  logic [8:0]  m_addr;
  logic [31:0] m_din;

  always @(posedge clk) begin
    m_csb   <= sram_csb0;
    m_web   <= sram_web0;
    m_wmask <= sram_wmask0;
    m_addr  <= sram_addr0;
    m_din   <= sram_din0;
  end

  always @(negedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 512; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
      sram_dout0 = '0;
      mem_loaded = 1'b1;
    end
    if (m_csb === 1'b0) begin
      if (m_web === 1'b0) begin
        for (int b = 0; b < 4; b++)
          if (m_wmask[b]) mem[m_addr][8*b +: 8] = m_din[8*b +: 8];
      end else begin
        sram_dout0 = mem[m_addr];
      end
    end
  end

  // Address 5 is rewritten twice (DEADBEEF, then bytes 0/2 <- 11223344) before the bulk reads.
  function automatic logic [31:0] exp_rd(input int a);
    return (a == 5) ? 32'hDE22_BE44 : 32'hC0DE_0000 + 32'(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    check("send_ready", 32'(req_ready), 32'd1);
    tick();
  endtask

  task automatic expect_rsp(input string tag, input logic we, input logic [31:0] d);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_we"}, 32'(rsp_we), 32'(we));
    check({tag, "_rdata"}, rsp_rdata, d);
  endtask

  int acc;
  logic [8:0] a;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;
    repeat (3) tick();

    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_we", 32'(rsp_we), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_csb", 32'(sram_csb0), 32'd1);
    check("rst_web", 32'(sram_web0), 32'd1);
    check("rst_wmask", 32'(sram_wmask0), 32'd0);
    check("rst_addr", 32'(sram_addr0), 32'd0);
    check("rst_din", sram_din0, 32'd0);

    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("idle_csb", 32'(sram_csb0), 32'd1);
      check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      tick();
    end

    // Full write then back-to-back read of the same address.
    send(1'b1, 9'h005, 32'hDEAD_BEEF, 4'b1111);
    check("wr_csb", 32'(sram_csb0), 32'd0);
    check("wr_web", 32'(sram_web0), 32'd0);
    check("wr_addr", 32'(sram_addr0), 32'h005);
    check("wr_din", sram_din0, 32'hDEAD_BEEF);
    check("wr_wmask", 32'(sram_wmask0), 32'hF);
    send(1'b0, 9'h005, 32'h0, 4'b0000);
    check("rd_csb", 32'(sram_csb0), 32'd0);
    check("rd_web", 32'(sram_web0), 32'd1);
    check("rd1_no_rsp_yet", 32'(rsp_valid), 32'd0);
    req_valid = 1'b0;
    tick();
    expect_rsp("raw_wr_rsp", 1'b1, 32'h0);
    tick();
    expect_rsp("raw_rd_rsp", 1'b0, 32'hDEAD_BEEF);
    tick();
    check("raw_drained", 32'(rsp_valid), 32'd0);
    check("raw_csb_idle", 32'(sram_csb0), 32'd1);

    // Partial byte write over DEADBEEF.
    send(1'b1, 9'h005, 32'h1122_3344, 4'b0101);
    send(1'b0, 9'h005, 32'h0, 4'b0000);
    req_valid = 1'b0;
    tick();
    expect_rsp("mask_wr_rsp", 1'b1, 32'h0);
    tick();
    expect_rsp("mask_rd_rsp", 1'b0, 32'hDE22_BE44);
    tick();
    check("mask_drained", 32'(rsp_valid), 32'd0);

    // A write with no byte enables still reaches the macro and still responds.
    send(1'b1, 9'h006, 32'hFFFF_FFFF, 4'b0000);
    check("wm0_csb", 32'(sram_csb0), 32'd0);
    check("wm0_wmask", 32'(sram_wmask0), 32'd0);
    send(1'b0, 9'h006, 32'h0, 4'b0000);
    req_valid = 1'b0;
    tick();
    expect_rsp("wm0_wr_rsp", 1'b1, 32'h0);
    tick();
    expect_rsp("wm0_rd_rsp", 1'b0, 32'hC0DE_0006);
    tick();
    check("wm0_drained", 32'(rsp_valid), 32'd0);

    // Streaming reads of 0..15, one per cycle.
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = 9'(c);
        check("stream_ready", 32'(req_ready), 32'd1);
      end else begin
        req_valid = 1'b0;
      end
      tick();
      if (c >= 2) expect_rsp("stream_rsp", 1'b0, exp_rd(c - 2));
    end
    tick();
    check("stream_drained", 32'(rsp_valid), 32'd0);

    // Backpressure: exactly RSP_DEPTH accepts, then drain in order.
    rsp_ready = 1'b0;
    a = 9'd8;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = a;
      if (req_ready) begin
        acc++;
        a = a + 9'd1;
      end
      tick();
    end
    req_valid = 1'b0;
    check("bp_accepts", 32'(acc), 32'd4);
    check("bp_ready_low", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_rsp("bp_drain", 1'b0, exp_rd(8 + k));
      tick();
    end
    check("bp_drained", 32'(rsp_valid), 32'd0);
    check("bp_ready_high", 32'(req_ready), 32'd1);

    // Reset with three requests in flight.
    rsp_ready = 1'b0;
    send(1'b0, 9'h000, 32'h0, 4'b0000);
    send(1'b0, 9'h001, 32'h0, 4'b0000);
    send(1'b0, 9'h002, 32'h0, 4'b0000);
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_outstanding", 32'(dut.outstanding_q), 32'd0);
    check("mid_rst_csb", 32'(sram_csb0), 32'd1);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("after_rst_ready", 32'(req_ready), 32'd1);
    check("after_rst_no_replay", 32'(rsp_valid), 32'd0);
    send(1'b0, 9'h003, 32'h0, 4'b0000);
    req_valid = 1'b0;
    tick();
    check("fresh_latency", 32'(rsp_valid), 32'd0);
    tick();
    expect_rsp("fresh_rd_rsp", 1'b0, exp_rd(3));
    tick();
    check("fresh_drained", 32'(rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
